// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp patterns and count limits for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_A  = 3'd0,
        GA    = 3'd1,
        YA    = 3'd2,
        AR_B  = 3'd3,
        GB    = 3'd4,
        YB    = 3'd5,
        FLASH = 3'd6
    } phase_e;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int COUNT_W   = 5;
    localparam int COUNT_MAX = 24;

    // Road A lamp for a normal phase; FLASH is handled by the sequencer itself.
    function automatic logic [2:0] lamp_a(input phase_e ph);
        case (ph)
            GA:      return LAMP_G;
            YA:      return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] lamp_b(input phase_e ph);
        case (ph)
            GB:      return LAMP_G;
            YB:      return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Free-running 1 s prescaler: tick is high while the count sits at TICK_DIV-1.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk1,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)
            pre <= '0;
        else if (clr || pre == LAST)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    assign tick = (pre == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: phase FSM, seconds countdown, lamp and display-enable registers.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int T_ALLRED  = 1,
    parameter int T_GREEN_A = 20,
    parameter int T_GREEN_B = 15,
    parameter int T_YELLOW  = 3
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               night,
    output logic [2:0]         light_a,
    output logic [2:0]         light_b,
    output logic [COUNT_W-1:0] Count,
    output logic               eLED01,
    output logic               eLED23,
    output logic               tick
);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be >= 2");
    end
    if (T_ALLRED < 1 || T_ALLRED > COUNT_MAX || T_GREEN_A < 1 || T_GREEN_A > COUNT_MAX ||
        T_GREEN_B < 1 || T_GREEN_B > COUNT_MAX || T_YELLOW < 1 || T_YELLOW > COUNT_MAX) begin : g_bad_dur
        $error("phase durations must be in 1..24");
    end

    localparam logic [COUNT_W-1:0] D_AR = COUNT_W'(T_ALLRED);
    localparam logic [COUNT_W-1:0] D_GA = COUNT_W'(T_GREEN_A);
    localparam logic [COUNT_W-1:0] D_GB = COUNT_W'(T_GREEN_B);
    localparam logic [COUNT_W-1:0] D_Y  = COUNT_W'(T_YELLOW);

    phase_e             state, state_n;
    logic [COUNT_W-1:0] cnt_n;
    logic [2:0]         la_n, lb_n;
    logic               e01_n, e23_n;
    logic               leave_flash;

    // Leaving night mode restarts the second so AR_A gets a full guard interval.
    assign leave_flash = (state == FLASH) && !night;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk1 (clk1),
        .rst  (rst),
        .clr  (leave_flash),
        .tick (tick)
    );

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            AR_A:    return GA;
            GA:      return YA;
            YA:      return AR_B;
            AR_B:    return GB;
            GB:      return YB;
            default: return AR_A;
        endcase
    endfunction

    function automatic logic [COUNT_W-1:0] dur(input phase_e ph);
        case (ph)
            GA:      return D_GA;
            GB:      return D_GB;
            YA, YB:  return D_Y;
            default: return D_AR;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = Count;
        la_n    = light_a;
        lb_n    = light_b;
        e01_n   = eLED01;
        e23_n   = eLED23;
        if (state == FLASH) begin
            if (!night) begin
                state_n = AR_A;
                cnt_n   = D_AR;
                la_n    = LAMP_R;
                lb_n    = LAMP_R;
                e01_n   = 1'b1;
                e23_n   = 1'b0;
            end else if (tick) begin
                la_n = light_a ^ LAMP_Y;
                lb_n = light_b ^ LAMP_Y;
            end
        end else if (night) begin
            // Night takes priority over a coinciding phase-end tick.
            state_n = FLASH;
            cnt_n   = '0;
            la_n    = LAMP_Y;
            lb_n    = LAMP_Y;
            e01_n   = 1'b0;
            e23_n   = 1'b0;
        end else if (tick) begin
            if (Count == COUNT_W'(1)) begin
                state_n = next_phase(state);
                cnt_n   = dur(state_n);
                la_n    = lamp_a(state_n);
                lb_n    = lamp_b(state_n);
                e01_n   = (state_n == AR_A) || (state_n == GA) || (state_n == YA);
                e23_n   = (state_n == AR_B) || (state_n == GB) || (state_n == YB);
            end else begin
                cnt_n = Count - COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state   <= AR_A;
            Count   <= D_AR;
            light_a <= LAMP_R;
            light_b <= LAMP_R;
            eLED01  <= 1'b1;
            eLED23  <= 1'b1;
        end else begin
            state   <= state_n;
            Count   <= cnt_n;
            light_a <= la_n;
            light_b <= lb_n;
            eLED01  <= e01_n;
            eLED23  <= e23_n;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl against a seconds-level phase model.
module tb_traffic_phase_ctrl;

    localparam int TD = 4;

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       night = 1'b0;
    logic [2:0] light_a, light_b;
    logic [4:0] Count;
    logic       eLED01, eLED23, tick;

    int n_chk = 0;
    int n_err = 0;

    traffic_phase_ctrl #(
        .TICK_DIV(TD), .T_ALLRED(1), .T_GREEN_A(5), .T_GREEN_B(3), .T_YELLOW(2)
    ) dut (
        .clk1(clk1), .rst(rst), .night(night), .light_a(light_a), .light_b(light_b),
        .Count(Count), .eLED01(eLED01), .eLED23(eLED23), .tick(tick)
    );

    always #5 clk1 = ~clk1;

    // Model: phase index 0..5 walks the normal cycle, 6 is night flashing.
    int         dur_t [6] = '{1, 5, 2, 1, 3, 2};
    logic [2:0] la_t  [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] lb_t  [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    int         m_ph, m_cnt, m_pre;
    logic [2:0] m_la, m_lb;
    logic       m_e01, m_e23;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_cnt = 1; m_pre = 0;
        m_la = 3'b100; m_lb = 3'b100; m_e01 = 1'b1; m_e23 = 1'b1;
    endtask

    task automatic model_step();
        bit sec;
        if (rst) begin
            model_reset();
            return;
        end
        sec = (m_pre == TD - 1);
        m_pre = (m_ph == 6 && !night) ? 0 : (m_pre + 1) % TD;
        if (m_ph == 6) begin
            if (!night) begin
                m_ph = 0; m_cnt = 1; m_la = 3'b100; m_lb = 3'b100; m_e01 = 1'b1; m_e23 = 1'b0;
            end else if (sec) begin
                m_la = (m_la == 3'b010) ? 3'b000 : 3'b010;
                m_lb = m_la;
            end
        end else if (night) begin
            m_ph = 6; m_cnt = 0; m_la = 3'b010; m_lb = 3'b010; m_e01 = 1'b0; m_e23 = 1'b0;
        end else if (sec) begin
            if (m_cnt == 1) begin
                m_ph = (m_ph + 1) % 6;
                m_cnt = dur_t[m_ph];
                m_la = la_t[m_ph]; m_lb = lb_t[m_ph];
                m_e01 = (m_ph < 3); m_e23 = (m_ph >= 3);
            end else begin
                m_cnt--;
            end
        end
    endtask

    task automatic compare_all();
        chk("light_a", light_a, m_la);
        chk("light_b", light_b, m_lb);
        chk("Count", Count, m_cnt);
        chk("eLED01", eLED01, m_e01);
        chk("eLED23", eLED23, m_e23);
        chk("tick", tick, (m_pre == TD - 1));
        if (light_a[0] && light_b[0]) chk("dual_green", 1, 0);
    endtask

    task automatic cyc();
        @(posedge clk1);
        model_step();
        @(negedge clk1);
        compare_all();
    endtask

    task automatic wait_model(input int ph, input int cnt, input bit need_tick, input string tag);
        int n = 0;
        while (!(m_ph == ph && m_cnt == cnt && (!need_tick || m_pre == TD - 1)) && n < 500) begin
            cyc();
            n++;
        end
        if (n >= 500) chk({tag, "_timeout"}, 1, 0);
    endtask

    int g_a, g_b, y_a;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        repeat (2) cyc();
        chk("rst_Count", Count, 5'd1);
        chk("rst_la", light_a, 3'b100);
        chk("rst_lb", light_b, 3'b100);
        chk("rst_e01", eLED01, 1'b1);
        chk("rst_e23", eLED23, 1'b1);
        chk("rst_tick", tick, 1'b0);
        rst = 1'b0;

        // AR_A guard then GA, then the remainder of one full cycle
        repeat (4) cyc();
        chk("ga_Count", Count, 5'd5);
        chk("ga_la", light_a, 3'b001);
        chk("ga_e01", eLED01, 1'b1);
        chk("ga_e23", eLED23, 1'b0);
        g_a = 1; g_b = 0; y_a = 0;
        repeat (52) begin
            cyc();
            g_a += (light_a == 3'b001);
            g_b += (light_b == 3'b001);
            y_a += (light_a == 3'b010);
        end
        chk("dwell_GA", g_a, 20);
        chk("dwell_GB", g_b, 12);
        chk("dwell_YA", y_a, 8);
        chk("wrap_Count", Count, 5'd1);
        chk("wrap_la", light_a, 3'b100);
        chk("wrap_e23", eLED23, 1'b0);

        // night mid-GB at Count 2
        wait_model(4, 2, 1'b0, "gb2");
        night = 1'b1;
        cyc();
        chk("fl_Count", Count, 5'd0);
        chk("fl_la", light_a, 3'b010);
        chk("fl_lb", light_b, 3'b010);
        chk("fl_e01", eLED01, 1'b0);
        repeat (9) cyc();
        night = 1'b0;
        cyc();
        chk("exit_Count", Count, 5'd1);
        chk("exit_la", light_a, 3'b100);
        repeat (3) cyc();
        chk("exit_still_ar", light_a, 3'b100);
        cyc();
        chk("exit_ga", light_a, 3'b001);

        // night coincides with GA phase-end tick
        wait_model(1, 1, 1'b1, "ga_end");
        night = 1'b1;
        cyc();
        chk("tie_la", light_a, 3'b010);
        chk("tie_Count", Count, 5'd0);
        repeat (6) cyc();
        night = 1'b0;
        cyc();

        // random night activity
        repeat (2000) begin
            if ($urandom_range(0, 99) < 3) night = ~night;
            cyc();
        end
        night = 1'b0;
        cyc();

        // async reset mid-YB, between edges
        wait_model(5, 2, 1'b0, "yb");
        #2 rst = 1'b1;
        #1;
        chk("arst_Count", Count, 5'd1);
        chk("arst_la", light_a, 3'b100);
        chk("arst_lb", light_b, 3'b100);
        chk("arst_e23", eLED23, 1'b1);
        chk("arst_tick", tick, 1'b0);
        model_reset();
        cyc();
        rst = 1'b0;
        repeat (60) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
